// File: rtl/yags_predictor.sv
// YAGS conditional-branch direction predictor for the RV32I fetch stage.
// Holds a choice PHT of 2-bit counters, tagged T- and NT-direction caches,
// and a non-speculative global history register trained from execute.
// Lookup is registered (1-cycle latency); training takes effect next cycle.
// Optional statistics counters are enabled by defining YAGS_STATS_EN.
module yags_predictor #(
  parameter int CHOICE_BITS    = 10,
  parameter int CACHE_IDX_BITS = 8,
  parameter int TAG_BITS       = 6,
  parameter int GHR_BITS       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pred_valid_i,
  input  logic [31:0]         pred_pc_i,
  output logic                pred_valid_o,
  output logic                pred_taken_o,
  output logic                pred_hit_o,
  output logic [GHR_BITS-1:0] pred_ghr_o,
  input  logic                upd_valid_i,
  input  logic [31:0]         upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [GHR_BITS-1:0] upd_ghr_i
`ifdef YAGS_STATS_EN
  ,
  output logic [31:0]         stat_lookups_o,
  output logic [31:0]         stat_mispred_o
`endif
);

  localparam int CHOICE_N = 1 << CHOICE_BITS;
  localparam int CACHE_N  = 1 << CACHE_IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [1:0]          ctr;
  } entry_t;

  // 2-bit saturating counter step toward the given outcome.
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [1:0]          choice_q   [CHOICE_N];
  entry_t              t_cache_q  [CACHE_N];
  entry_t              nt_cache_q [CACHE_N];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic                pred_valid_q, pred_taken_q, pred_hit_q;
  logic [GHR_BITS-1:0] pred_ghr_q;

  // Only a subset of PC bits feeds the indices and tags.
  logic unused_pc;
  assign unused_pc = ^{pred_pc_i, upd_pc_i};

  // ---------------- lookup path (current GHR, pre-edge tables) -------------
  logic [CHOICE_BITS-1:0]    p_choice_idx;
  logic [CACHE_IDX_BITS-1:0] p_cache_idx;
  logic [TAG_BITS-1:0]       p_tag;
  logic                      p_bias, p_hit, p_taken;
  entry_t                    p_ent;

  // Index the tables and form the lookup prediction.
  always_comb begin
    p_choice_idx = pred_pc_i[CHOICE_BITS+1:2];
    p_cache_idx  = pred_pc_i[CACHE_IDX_BITS+1:2] ^ CACHE_IDX_BITS'(ghr_q);
    p_tag        = pred_pc_i[CACHE_IDX_BITS+TAG_BITS+1:CACHE_IDX_BITS+2];
    p_bias       = choice_q[p_choice_idx][1];
    p_ent        = p_bias ? nt_cache_q[p_cache_idx] : t_cache_q[p_cache_idx];
    p_hit        = p_ent.valid && (p_ent.tag == p_tag);
    p_taken      = p_hit ? p_ent.ctr[1] : p_bias;
  end

  // ---------------- update path (history captured at predict time) ---------
  logic [CHOICE_BITS-1:0]    u_choice_idx;
  logic [CACHE_IDX_BITS-1:0] u_cache_idx;
  logic [TAG_BITS-1:0]       u_tag;
  logic                      u_bias, u_hit, u_pred, cache_we;
  entry_t                    u_ent, entry_d;
  logic [1:0]                u_choice, choice_d;

  // Recompute the prediction for the resolved branch and derive table writes.
  always_comb begin
    u_choice_idx = upd_pc_i[CHOICE_BITS+1:2];
    u_cache_idx  = upd_pc_i[CACHE_IDX_BITS+1:2] ^ CACHE_IDX_BITS'(upd_ghr_i);
    u_tag        = upd_pc_i[CACHE_IDX_BITS+TAG_BITS+1:CACHE_IDX_BITS+2];
    u_choice     = choice_q[u_choice_idx];
    u_bias       = u_choice[1];
    u_ent        = u_bias ? nt_cache_q[u_cache_idx] : t_cache_q[u_cache_idx];
    u_hit        = u_ent.valid && (u_ent.tag == u_tag);
    u_pred       = u_hit ? u_ent.ctr[1] : u_bias;

    entry_d  = u_ent;
    cache_we = 1'b0;
    choice_d = u_choice;
    ghr_d    = {ghr_q[GHR_BITS-2:0], upd_taken_i};

    if (u_hit) begin
      entry_d.ctr = sat_ctr(u_ent.ctr, upd_taken_i);
      cache_we    = 1'b1;
    end else if (upd_taken_i != u_bias) begin
      entry_d.valid = 1'b1;
      entry_d.tag   = u_tag;
      entry_d.ctr   = upd_taken_i ? 2'b10 : 2'b01;
      cache_we      = 1'b1;
    end

    // A correct cache exception leaves the bias alone so it keeps filtering.
    if (!(u_hit && (u_pred == upd_taken_i) && (upd_taken_i != u_bias)))
      choice_d = sat_ctr(u_choice, upd_taken_i);
  end

  // Choice PHT training.
  // NOTE: the tables are flops, not RAM, because reset must clear every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            choice_q <= '{default: 2'b01};
    else if (upd_valid_i) choice_q[u_choice_idx] <= choice_d;
  end

  // T-cache write: hit training or allocation when bias was not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                t_cache_q <= '{default: '0};
    else if (upd_valid_i && cache_we && !u_bias) t_cache_q[u_cache_idx] <= entry_d;
  end

  // NT-cache write: hit training or allocation when bias was taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  nt_cache_q <= '{default: '0};
    else if (upd_valid_i && cache_we && u_bias) nt_cache_q[u_cache_idx] <= entry_d;
  end

  // Non-speculative global history, shifted only by resolved branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ghr_q <= '0;
    else if (upd_valid_i) ghr_q <= ghr_d;
  end

  // Registered prediction; payload holds when no request is made.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_ghr_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_i;
      if (pred_valid_i) begin
        pred_taken_q <= p_taken;
        pred_hit_q   <= p_hit;
        pred_ghr_q   <= ghr_q;
      end
    end
  end

  assign pred_valid_o = pred_valid_q;
  assign pred_taken_o = pred_taken_q;
  assign pred_hit_o   = pred_hit_q;
  assign pred_ghr_o   = pred_ghr_q;

`ifdef YAGS_STATS_EN
  logic [31:0] stat_lookups_q, stat_mispred_q;

  // Saturating lookup and misprediction counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lookups_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (pred_valid_i && (stat_lookups_q != '1))
        stat_lookups_q <= stat_lookups_q + 32'd1;
      if (upd_valid_i && (u_pred != upd_taken_i) && (stat_mispred_q != '1))
        stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_lookups_o = stat_lookups_q;
  assign stat_mispred_o = stat_mispred_q;
`endif

endmodule

// File: tb/tb_yags_predictor.sv
// Self-checking bench for yags_predictor: table-driven lookup/update vectors
// with a queue scoreboard, plus hand-written reset and same-cycle sequences.
// Stats checks are compiled in when YAGS_STATS_EN is defined.
module tb_yags_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid_i;
  logic [31:0] pred_pc_i;
  logic        pred_valid_o, pred_taken_o, pred_hit_o;
  logic [7:0]  pred_ghr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [7:0]  upd_ghr_i;
`ifdef YAGS_STATS_EN
  logic [31:0] stat_lookups_o, stat_mispred_o;
`endif

  yags_predictor dut (
    .clk          (clk),
    .reset        (reset),
    .pred_valid_i (pred_valid_i),
    .pred_pc_i    (pred_pc_i),
    .pred_valid_o (pred_valid_o),
    .pred_taken_o (pred_taken_o),
    .pred_hit_o   (pred_hit_o),
    .pred_ghr_o   (pred_ghr_o),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_taken_i  (upd_taken_i),
    .upd_ghr_i    (upd_ghr_i)
`ifdef YAGS_STATS_EN
    ,
    .stat_lookups_o (stat_lookups_o),
    .stat_mispred_o (stat_mispred_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [7:0]  ug;
    logic        et;
    logic        eh;
    logic [7:0]  eg;
  } vec_t;

  typedef struct {
    logic       t;
    logic       h;
    logic [7:0] g;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t last;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] lpc,
                              input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [7:0] ug,
                              input logic et, input logic eh, input logic [7:0] eg);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.uv = uv; v.upc = upc; v.ut = ut; v.ug = ug;
    v.et = et; v.eh = eh; v.eg = eg;
    return v;
  endfunction

  // Eight resolved branches at pc 0x1000 shift the target into the GHR.
  task automatic push_set_ghr(input logic [7:0] target);
    for (int i = 7; i >= 0; i--)
      tbl.push_back(mk(0, 0, 1, 32'h1000, target[i], 8'h00, 0, 0, 8'h00));
  endtask

  // One clock: drive at negedge, sample at the following negedge.
  task automatic cyc(input vec_t v);
    exp_t e;
    pred_valid_i = v.lv;  pred_pc_i = v.lpc;
    upd_valid_i  = v.uv;  upd_pc_i  = v.upc;
    upd_taken_i  = v.ut;  upd_ghr_i = v.ug;
    if (v.lv) begin
      e.t = v.et; e.h = v.eh; e.g = v.eg;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("pred_valid", {31'd0, pred_valid_o}, {31'd0, v.lv});
    if (pred_valid_o) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pred_taken", {31'd0, pred_taken_o}, {31'd0, e.t});
        check("pred_hit",   {31'd0, pred_hit_o},   {31'd0, e.h});
        check("pred_ghr",   {24'd0, pred_ghr_o},   {24'd0, e.g});
        last = e;
      end
    end else begin
      check("hold_taken", {31'd0, pred_taken_o}, {31'd0, last.t});
      check("hold_hit",   {31'd0, pred_hit_o},   {31'd0, last.h});
      check("hold_ghr",   {24'd0, pred_ghr_o},   {24'd0, last.g});
    end
  endtask

  task automatic idle_inputs();
    pred_valid_i = 0; pred_pc_i = 0;
    upd_valid_i  = 0; upd_pc_i  = 0; upd_taken_i = 0; upd_ghr_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, pred_valid_o}, 32'd0);
    check("rst_taken", {31'd0, pred_taken_o}, 32'd0);
    check("rst_hit",   {31'd0, pred_hit_o},   32'd0);
    check("rst_ghr",   {24'd0, pred_ghr_o},   32'd0);
    reset = 1'b0;
    sb.delete();
    last = '{t: 0, h: 0, g: 8'h00};
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();

    // ---- table: reset lookup, allocation, and the choice-exception path ----
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 8'h00));        // miss, weak NT
    tbl.push_back(mk(0, 0, 1, 32'h100, 1, 8'h00, 0, 0, 8'h00));    // T alloc, choice 10
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 0, 1, 0, 8'h01));        // NT idx 0x41 miss
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 1, 32'h200, 1, 8'h00, 0, 0, 8'h00));  // choice -> 11
    tbl.push_back(mk(0, 0, 1, 32'h200, 0, 8'h5A, 0, 0, 8'h00));    // NT 0xDA alloc 01
    push_set_ghr(8'h5A);
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 8'h5A));        // NT hit, ctr 01
    tbl.push_back(mk(0, 0, 1, 32'h200, 0, 8'h5A, 0, 0, 8'h00));    // choice kept, ctr 00
    push_set_ghr(8'h5A);
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 8'h5A));        // still NT-cache hit
    tbl.push_back(mk(0, 0, 1, 32'h200, 1, 8'h5A, 0, 0, 8'h00));    // ctr 00 -> 01
    push_set_ghr(8'h5A);
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 0, 0, 1, 8'h5A));        // ctr 01 -> NT

    do_reset();
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // ---- same-cycle lookup and update of the same entry ----
    do_reset();
    cyc(mk(1, 32'h100, 1, 32'h100, 1, 8'h00, 0, 0, 8'h00));        // sees pre-update
    cyc(mk(1, 32'h100, 0, 0, 0, 0, 1, 0, 8'h01));                  // sees trained state

    // ---- asynchronous reset in the middle of a valid prediction ----
    do_reset();
    cyc(mk(0, 0, 1, 32'h200, 1, 8'h00, 0, 0, 8'h00));              // choice[0x80]=10
    cyc(mk(1, 32'h200, 0, 0, 0, 0, 1, 0, 8'h01));                  // pred_valid_o=1
    #2;
    reset = 1'b1;
    pred_valid_i = 1'b1; pred_pc_i = 32'h200;
    #1;
    check("async_valid", {31'd0, pred_valid_o}, 32'd0);
    check("async_taken", {31'd0, pred_taken_o}, 32'd0);
    check("async_ghr",   {24'd0, pred_ghr_o},   32'd0);
    @(posedge clk);
    @(negedge clk);
    check("held_rst_valid", {31'd0, pred_valid_o}, 32'd0);
    reset = 1'b0;
    pred_valid_i = 1'b0;
    sb.delete();
    last = '{t: 0, h: 0, g: 8'h00};
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h00));                        // request dropped
    cyc(mk(1, 32'h200, 0, 0, 0, 0, 0, 0, 8'h00));                  // tables cleared

`ifdef YAGS_STATS_EN
    // ---- statistics counters and saturation ----
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(mk(1, 32'h100 + 32'(i * 4), 0, 0, 0, 0, 0, 0, 8'h00));
    cyc(mk(0, 0, 1, 32'h300, 1, 8'h00, 0, 0, 8'h00));
    cyc(mk(0, 0, 1, 32'h400, 1, 8'h00, 0, 0, 8'h00));
    cyc(mk(0, 0, 1, 32'h500, 1, 8'h00, 0, 0, 8'h00));
    check("stat_lookups", stat_lookups_o, 32'd10);
    check("stat_mispred", stat_mispred_o, 32'd3);
    force dut.stat_lookups_q = 32'hFFFF_FFFE;
    force dut.stat_mispred_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_lookups_q;
    release dut.stat_mispred_q;
    for (int i = 0; i < 3; i++)
      cyc(mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 8'h07));
    cyc(mk(0, 0, 1, 32'h600, 1, 8'h00, 0, 0, 8'h00));
    cyc(mk(0, 0, 1, 32'h700, 1, 8'h00, 0, 0, 8'h00));
    cyc(mk(0, 0, 1, 32'h800, 1, 8'h00, 0, 0, 8'h00));
    check("stat_lookups_sat", stat_lookups_o, 32'hFFFF_FFFF);
    check("stat_mispred_sat", stat_mispred_o, 32'hFFFF_FFFF);
`endif

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
